// File: rtl/kbd_entry_fifo.sv
// kbd_entry_fifo: synchronised, debounced keypad front-end that queues a data nibble
// on every ENTER press and serves the queue head to the processor's keyboard bus.
module kbd_entry_fifo #(
    parameter int DEB_CYCLES = 4,
    parameter int DEPTH      = 4
) (
    input  logic                     clk1,
    input  logic                     nMainClear,
    input  logic [3:0]               key_raw,
    input  logic                     enter_raw,
    input  logic                     kbd_rd,
    input  logic                     ovf_clr,
    output logic [3:0]               kbd_data,
    output logic                     kbd_valid,
    output logic                     kbd_full,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    meta_q, sync_q, deb_q, deb_d;
    logic [7:0]    cnt_q [5];
    logic [7:0]    cnt_d [5];
    logic          enter_prev_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    mem_q [DEPTH];
    logic          push, pop, push_acc;

    // Line 4 is ENTER, lines 3..0 are the data keys.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = (sync_q[i] == deb_q[i] || cnt_q[i] == 8'(DEB_CYCLES - 1)) ? 8'd0 : cnt_q[i] + 8'd1;
            deb_d[i] = (sync_q[i] != deb_q[i] && cnt_q[i] == 8'(DEB_CYCLES - 1)) ? sync_q[i] : deb_q[i];
        end
    end

    // A full FIFO still accepts a press when the head is popped in the same cycle.
    always_comb begin
        push     = deb_q[4] & ~enter_prev_q;
        pop      = kbd_rd & kbd_valid;
        push_acc = push & (~kbd_full | pop);
        wr_ptr_d = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_acc) - CW'(pop);
        ovf_d    = (push & kbd_full & ~pop) | (ovf_q & ~ovf_clr);
    end

    assign kbd_valid = count_q != '0;
    assign kbd_full  = count_q == CW'(DEPTH);
    assign kbd_data  = kbd_valid ? mem_q[rd_ptr_q] : 4'h0;
    assign ovf       = ovf_q;
    assign count     = count_q;

    always_ff @(posedge clk1 or negedge nMainClear) begin
        if (!nMainClear) begin
            meta_q       <= '0;
            sync_q       <= '0;
            deb_q        <= '0;
            cnt_q        <= '{default: '0};
            enter_prev_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            meta_q       <= {enter_raw, key_raw};
            sync_q       <= meta_q;
            deb_q        <= deb_d;
            cnt_q        <= cnt_d;
            enter_prev_q <= deb_q[4];
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
        end
    end

    always_ff @(posedge clk1) begin
        if (push_acc) mem_q[wr_ptr_q] <= deb_q[3:0];
    end
endmodule

// File: tb/tb_kbd_entry_fifo.sv
// tb_kbd_entry_fifo: randomized and directed checks of kbd_entry_fifo against a
// queue-based reference model of debounce, press detection and FIFO behaviour.
module tb_kbd_entry_fifo;
    localparam int DEB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk1 = 1'b0;
    logic          nMainClear = 1'b0;
    logic [3:0]    key_raw = 4'h0;
    logic          enter_raw = 1'b0;
    logic          kbd_rd = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [3:0]    kbd_data;
    logic          kbd_valid, kbd_full, ovf;
    logic [CW-1:0] count;

    int vecs = 0;
    int errs = 0;

    kbd_entry_fifo #(.DEB_CYCLES(DEB), .DEPTH(DEPTH)) dut (
        .clk1(clk1), .nMainClear(nMainClear), .key_raw(key_raw), .enter_raw(enter_raw),
        .kbd_rd(kbd_rd), .ovf_clr(ovf_clr), .kbd_data(kbd_data), .kbd_valid(kbd_valid),
        .kbd_full(kbd_full), .ovf(ovf), .count(count)
    );

    always #5 clk1 = ~clk1;

    // Reference model: a line's debounced value flips once its last DEB synchronised
    // samples all disagree with it; the FIFO is a plain queue.
    logic [4:0] m_s1, m_s2, m_deb;
    logic       m_prev, m_ovf;
    logic [4:0] m_hist [$];
    logic [3:0] m_q [$];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = 1'b0; m_ovf = 1'b0;
        m_hist.delete();
        m_q.delete();
    endtask

    function automatic logic [CW+6:0] exp_out();
        logic [3:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 4'h0;
        return {h, m_q.size() > 0, m_q.size() == DEPTH, m_ovf, CW'(m_q.size())};
    endfunction

    function automatic logic [CW+6:0] obs();
        return {kbd_data, kbd_valid, kbd_full, ovf, count};
    endfunction

    task automatic tick();
        logic push, pop, full;
        @(posedge clk1);
        push = m_deb[4] & ~m_prev;
        pop  = kbd_rd && m_q.size() > 0;
        full = m_q.size() == DEPTH;
        if (pop) void'(m_q.pop_front());
        if (push && (!full || pop)) m_q.push_back(m_deb[3:0]);
        if (push && full && !pop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_prev = m_deb[4];
        m_hist.push_back(m_s2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        if (m_hist.size() == DEB) begin
            for (int i = 0; i < 5; i++) begin
                bit all;
                all = 1'b1;
                foreach (m_hist[j]) if (m_hist[j][i] == m_deb[i]) all = 1'b0;
                if (all) m_deb[i] = ~m_deb[i];
            end
        end
        m_s2 = m_s1;
        m_s1 = {enter_raw, key_raw};
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_raw = k;
        repeat (2) tick();
        enter_raw = 1'b1;
        repeat (7) tick();
        enter_raw = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        #1;
        vecs++;
        if (obs() !== '0) begin errs++; $display("FAIL reset_power: got %h want 0", obs()); end
        @(negedge clk1) nMainClear = 1'b1;
        model_reset();
        press(4'h1);
        press(4'h2);
        vecs++;
        if (count !== CW'(2) || obs() !== exp_out()) begin
            errs++; $display("FAIL reset_prefill: got %h want %h", obs(), exp_out());
        end
        key_raw = 4'h5;
        enter_raw = 1'b1;
        repeat (3) tick();
        #2 nMainClear = 1'b0;
        #1;
        vecs++;
        if (obs() !== '0) begin errs++; $display("FAIL reset_async: got %h want 0", obs()); end
        model_reset();
        key_raw = 4'h0;
        enter_raw = 1'b0;
        repeat (2) @(negedge clk1);
        nMainClear = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            vecs++;
            if (obs() !== '0 || obs() !== exp_out()) begin
                errs++; $display("FAIL reset_idle[%0d]: got %h want %h", i, obs(), exp_out());
            end
        end
    endtask

    task automatic test_single();
        key_raw = 4'hA;
        enter_raw = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            vecs++;
            if (obs() !== exp_out()) begin
                errs++; $display("FAIL single_model[%0d]: got %h want %h", i, obs(), exp_out());
            end
            if (i == 5) begin
                vecs++;
                if (kbd_valid !== 1'b0) begin errs++; $display("FAIL single_early: valid got %b want 0", kbd_valid); end
            end
        end
        vecs++;
        if ({kbd_valid, kbd_data, count} !== {1'b1, 4'hA, CW'(1)}) begin
            errs++; $display("FAIL single_entry: got v=%b d=%h c=%0d want v=1 d=a c=1", kbd_valid, kbd_data, count);
        end
        enter_raw = 1'b0;
        kbd_rd = 1'b1;
        tick();
        kbd_rd = 1'b0;
        vecs++;
        if ({kbd_valid, kbd_data} !== 5'b0 || obs() !== exp_out()) begin
            errs++; $display("FAIL single_pop: got %h want %h", obs(), exp_out());
        end
        repeat (6) tick();
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 60; i++) begin
            enter_raw = (i == 3) ? 1'b0 : 1'b1;
            tick();
            vecs++;
            if (obs() !== exp_out()) begin
                errs++; $display("FAIL bounce_model[%0d]: got %h want %h", i, obs(), exp_out());
            end
            if (i == 9 || i == 10) begin
                vecs++;
                if (kbd_valid !== (i == 10)) begin
                    errs++; $display("FAIL bounce_timing[%0d]: valid got %b want %b", i, kbd_valid, i == 10);
                end
            end
        end
        vecs++;
        if (count !== CW'(1)) begin errs++; $display("FAIL bounce_once: count got %0d want 1", count); end
        enter_raw = 1'b0;
        repeat (6) tick();
        kbd_rd = 1'b1;
        tick();
        kbd_rd = 1'b0;
    endtask

    task automatic test_order_wrap();
        logic [3:0] seq [6];
        seq = '{4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD};
        for (int j = 0; j < 4; j++) press(seq[j]);
        vecs++;
        if (kbd_full !== 1'b1 || count !== CW'(4) || obs() !== exp_out()) begin
            errs++; $display("FAIL order_full: got %h want %h", obs(), exp_out());
        end
        for (int j = 0; j < 6; j++) begin
            if (j == 2) begin press(seq[4]); press(seq[5]); end
            vecs++;
            if (kbd_data !== seq[j] || obs() !== exp_out()) begin
                errs++; $display("FAIL order_head[%0d]: got %h want %h", j, kbd_data, seq[j]);
            end
            kbd_rd = 1'b1;
            tick();
            kbd_rd = 1'b0;
        end
        vecs++;
        if (kbd_valid !== 1'b0 || obs() !== exp_out()) begin
            errs++; $display("FAIL order_drained: got %h want %h", obs(), exp_out());
        end
    endtask

    task automatic test_overflow();
        logic [3:0] r [4];
        for (int j = 0; j < 4; j++) begin
            r[j] = 4'($urandom_range(0, 14));
            press(r[j]);
        end
        press(4'hF);
        vecs++;
        if (ovf !== 1'b1 || count !== CW'(4) || kbd_data !== r[0] || obs() !== exp_out()) begin
            errs++; $display("FAIL ovf_drop: got %h want ovf=1 c=4 d=%h", obs(), r[0]);
        end
        enter_raw = 1'b1;
        for (int i = 0; i < 7; i++) begin
            kbd_rd = (i == 6);
            tick();
        end
        kbd_rd = 1'b0;
        vecs++;
        if (ovf !== 1'b1 || count !== CW'(4) || kbd_data !== r[1] || obs() !== exp_out()) begin
            errs++; $display("FAIL ovf_pushpop: got %h want ovf=1 c=4 d=%h", obs(), r[1]);
        end
        enter_raw = 1'b0;
        repeat (6) tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        vecs++;
        if (ovf !== 1'b0 || obs() !== exp_out()) begin
            errs++; $display("FAIL ovf_clear: got %b want 0", ovf);
        end
        kbd_rd = 1'b1;
        repeat (4) tick();
        kbd_rd = 1'b0;
        vecs++;
        if (count !== '0 || obs() !== exp_out()) begin
            errs++; $display("FAIL ovf_drain: got %h want %h", obs(), exp_out());
        end
    endtask

    task automatic test_empty_read();
        int vcyc;
        vcyc = 0;
        kbd_rd = 1'b1;
        key_raw = 4'h6;
        repeat (2) tick();
        enter_raw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (kbd_valid) begin
                vcyc++;
                vecs++;
                if (kbd_data !== 4'h6) begin errs++; $display("FAIL empty_rd_data: got %h want 6", kbd_data); end
            end
            vecs++;
            if (obs() !== exp_out()) begin
                errs++; $display("FAIL empty_rd_model[%0d]: got %h want %h", i, obs(), exp_out());
            end
        end
        vecs++;
        if (vcyc != 1 || count !== '0) begin
            errs++; $display("FAIL empty_rd: valid cycles got %0d want 1, count got %0d want 0", vcyc, count);
        end
        kbd_rd = 1'b0;
        enter_raw = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                enter_raw = 1'($urandom);
                hold = $urandom_range(1, 9);
            end
            hold--;
            if ($urandom_range(0, 7) == 0) key_raw = 4'($urandom);
            kbd_rd = (i < 1500) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            tick();
            vecs++;
            if (obs() !== exp_out()) begin
                errs++; $display("FAIL random[%0d]: got %h want %h", i, obs(), exp_out());
            end
        end
        kbd_rd = 1'b0;
        ovf_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_bounce();
        test_order_wrap();
        test_overflow();
        test_empty_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/kbd_entry_fifo.md
# kbd_entry_fifo

Keypad front-end for the 4-bit microprocessor. It synchronises and debounces four data keys and one ENTER key, and on each debounced ENTER press it captures the data nibble into a small FIFO. It presents the FIFO head to the processor's keyboard input bus (kbd1[1..4]) with a valid/read handshake, so the processor's In instruction consumes one queued nibble per read.

## Interface
- DEB_CYCLES, 4: consecutive stable synchronised samples required before a debounced key changes; legal range 2..255.
- DEPTH, 4: FIFO depth in nibbles; power of 2, range 2..16.

- clk1  in  1  single system clock; all state changes on its rising edge.
- nMainClear  in  1  asynchronous, active-low reset.
- key_raw  in  4  raw data keys; bit i drives kbd1[i+1].
- enter_raw  in  1  raw ENTER key; high while pressed.
- kbd_rd  in  1  processor read strobe; pops the head when kbd_valid=1.
- ovf_clr  in  1  synchronous clear of ovf.
- kbd_data  out  4  FIFO head nibble; 0 when empty.
- kbd_valid  out  1  FIFO not empty.
- kbd_full  out  1  FIFO holds DEPTH entries.
- ovf  out  1  sticky flag: a press was dropped because the FIFO was full.
- count  out  clog2(DEPTH)+1  number of queued entries.

## Operation
- Synchroniser: 2 flops per line (5 lines). sync_q is the second-flop output.
- Debouncer, per line: state deb_q and counter cnt.
  - sync_q == deb_q: cnt <= 0.
  - sync_q != deb_q and cnt == DEB_CYCLES-1: deb_q <= sync_q, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - A glitch shorter than DEB_CYCLES synchronised samples never reaches deb_q.
- Press detect: enter_prev <= deb_enter. push = deb_enter & ~enter_prev, a single-cycle pulse per press. Release never pushes.
- Write: on push, the debounced data nibble deb_key (value at that edge) is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Read: pop = kbd_rd & kbd_valid. On pop, rd_ptr increments modulo DEPTH. kbd_rd while empty is ignored and has no side effects.
- Counting: count updates by +push_acc − pop. Here push_acc = push & (~kbd_full | pop).
- Full with push and no pop: the entry is dropped, FIFO contents are unchanged, and ovf <= 1.
- Full with push and pop in the same cycle: both are accepted and count stays DEPTH.
- Empty with push and kbd_rd in the same cycle: the push is accepted and the read is ignored.
- ovf: set on a drop; cleared by ovf_clr. A simultaneous set and clear leaves ovf=1 (set wins).
- kbd_data = mem[rd_ptr] when kbd_valid, else 4'h0. Driven from registered state only, with no comb path from inputs.
- Reset (nMainClear=0, asynchronous):
  - All sync flops, deb_q, cnt, enter_prev, pointers, count and ovf go to 0.
  - Outputs: kbd_data=0, kbd_valid=0, kbd_full=0, ovf=0, count=0.
  - FIFO storage need not be cleared.
  - Reset mid-debounce or mid-handshake discards all pending state.
  - Release is synchronised by the user. The first edge after release behaves as ordinary operation from the all-zero state.
  - A key held through reset is seen as a new press after release.

## Timing
- enter_raw rises and is stable before edge N: sync_q=1 after edge N+1, deb_enter=1 after edge N+1+DEB_CYCLES, push at edge N+2+DEB_CYCLES.
- kbd_valid rises after edge N+2+DEB_CYCLES (6 edges with the default).
- The data keys must be stable for at least DEB_CYCLES+1 edges before ENTER's push edge to be captured.
- A pop at edge M: the next head is visible on kbd_data after edge M, and kbd_valid falls after M if that was the last entry.
- Maximum throughput: 1 push and 1 pop per cycle.
- Pointers wrap from DEPTH-1 to 0 with no bubble.

## Test plan
- Reset values:
  - Stimulus: assert nMainClear=0 mid-debounce with 2 entries queued.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - After release, with no key activity: outputs stay 0 for 20 cycles.
- Single entry (DEB_CYCLES=4):
  - Stimulus: key_raw=4'hA held, then enter_raw held from before edge 0.
  - Required: kbd_valid=1 and kbd_data=4'hA after edge 6, count=1.
  - Then kbd_rd for 1 cycle: kbd_valid=0 and kbd_data=0.
- Bounce rejection:
  - Stimulus: enter_raw toggled high for 3 clocks, low for 1, high for 2, then held high.
  - Required: exactly one push, occurring DEB_CYCLES+1 edges after the final rise reaches sync_q.
  - Holding ENTER for 50 cycles: no further push.
- FIFO order and wrap:
  - Stimulus: push 3, 5, 7, 9; pop 2; push B, D; pop 4.
  - Required: kbd_data sequence 3, 5, 7, 9, B, D; kbd_full=1 after the 4th push.
- Overflow:
  - Stimulus: with the FIFO full, press ENTER with key 4'hF.
  - Required: ovf=1, count=4, head unchanged.
  - Then the same press with kbd_rd asserted on the push edge: accepted, count=4, ovf stays 1.
  - Then ovf_clr: ovf=0.
- Empty-read corner:
  - Stimulus: kbd_rd held high continuously while a press of 4'h6 arrives.
  - Required: the push is accepted, kbd_valid=1 for exactly 1 cycle, then the entry is popped on the next edge and count returns to 0.
